// File: rtl/jesd204b_dll_tx_lane.sv
// JESD204B transmit data link layer for one lane: CGS -> ILAS -> DATA start-up
// under receiver SYNC~, optional self-synchronous scrambling, octets + K flags out.
module jesd204b_dll_tx_lane #(
  parameter int LANE_WIDTH = 32,
  parameter int F          = 4,
  parameter int K          = 32,
  parameter int ILAS_MF    = 4,
  parameter int SCRAMBLE   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sync_n,
  input  logic [LANE_WIDTH-1:0]   tx_datain,
  input  logic [111:0]            cfg_octets,
  output logic                    tx_ready,
  output logic [LANE_WIDTH-1:0]   tx_dataout,
  output logic [LANE_WIDTH/8-1:0] tx_charisk,
  output logic [1:0]              link_state,
  output logic [7:0]              sync_err_cnt
);
  localparam int NB      = LANE_WIDTH / 8;
  localparam int MF_CLKS = F * K / NB;
  localparam int LW      = (MF_CLKS > 1) ? $clog2(MF_CLKS) : 1;
  localparam int MW      = (ILAS_MF > 1) ? $clog2(ILAS_MF) : 1;

  localparam logic [1:0] ST_CGS  = 2'd0;
  localparam logic [1:0] ST_ILAS = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]            state;
  logic [LW-1:0]         lmfc_cnt;
  logic [MW-1:0]         ilas_mf;
  logic                  sync_q, sync_d, was_data;
  logic [14:0]           scr;
  logic                  lmfc_last, lost, pulse;
  logic [LANE_WIDTH-1:0] ilas_word, scr_word;
  logic [NB-1:0]         ilas_k;
  logic [14:0]           scr_next;

  assign lmfc_last  = (lmfc_cnt == LW'(MF_CLKS - 1));
  assign lost       = (state != ST_CGS) && !sync_q && !sync_d;
  // a lone low cycle seen entirely inside DATA, detected as it rises again
  assign pulse      = (state == ST_DATA) && was_data && sync_q && !sync_d;
  assign tx_ready   = (state == ST_DATA);
  assign link_state = state;

  always_comb begin
    logic [7:0] o;
    logic [3:0] idx;
    ilas_word = '0;
    ilas_k    = '0;
    for (int b = 0; b < NB; b++) begin
      o   = 8'(lmfc_cnt * NB + b);
      idx = 4'(o - 8'd2);
      if (o == 8'd0) begin
        ilas_word[8*b +: 8] = 8'h1C;
        ilas_k[b]           = 1'b1;
      end else if (ilas_mf == MW'(1) && o == 8'd1) begin
        ilas_word[8*b +: 8] = 8'h9C;
        ilas_k[b]           = 1'b1;
      end else if (ilas_mf == MW'(1) && o >= 8'd2 && o <= 8'd15) begin
        ilas_word[8*b +: 8] = cfg_octets[{idx, 3'b000} +: 8];
      end else if (o == 8'(F * K - 1)) begin
        ilas_word[8*b +: 8] = 8'h7C;
        ilas_k[b]           = 1'b1;
      end else begin
        ilas_word[8*b +: 8] = o;
      end
    end
  end

  // sb[k] holds scrambled stream bit k-15; the low 15 entries come from the saved state
  always_comb begin
    logic [LANE_WIDTH+14:0] sb;
    int n, pos;
    sb       = '0;
    scr_word = '0;
    for (int j = 0; j < 15; j++) sb[14-j] = scr[j];
    for (n = 0; n < LANE_WIDTH; n++) begin
      pos        = 8 * (n / 8) + (7 - (n % 8));
      sb[n+15]   = tx_datain[pos] ^ sb[n+1] ^ sb[n];
      scr_word[pos] = sb[n+15];
    end
    for (int j = 0; j < 15; j++) scr_next[j] = sb[LANE_WIDTH+14-j];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_CGS;
      lmfc_cnt     <= '0;
      ilas_mf      <= '0;
      sync_q       <= 1'b0;
      sync_d       <= 1'b0;
      was_data     <= 1'b0;
      scr          <= '0;
      sync_err_cnt <= '0;
      tx_dataout   <= {NB{8'hBC}};
      tx_charisk   <= '1;
    end else begin
      sync_q   <= sync_n;
      sync_d   <= sync_q;
      was_data <= (state == ST_DATA);
      lmfc_cnt <= lmfc_last ? '0 : lmfc_cnt + 1'b1;

      if (pulse && sync_err_cnt != 8'hFF) sync_err_cnt <= sync_err_cnt + 8'd1;

      scr <= (SCRAMBLE != 0 && state == ST_DATA && !lost) ? scr_next : '0;

      case (state)
        ST_CGS: if (sync_q && lmfc_last) state <= ST_ILAS;
        ST_ILAS:
          if (lost) begin
            state   <= ST_CGS;
            ilas_mf <= '0;
          end else if (lmfc_last) begin
            if (ilas_mf == MW'(ILAS_MF - 1)) begin
              state   <= ST_DATA;
              ilas_mf <= '0;
            end else begin
              ilas_mf <= ilas_mf + 1'b1;
            end
          end
        ST_DATA: if (lost) state <= ST_CGS;
        default: state <= ST_CGS;
      endcase

      case (state)
        ST_ILAS: begin
          tx_dataout <= ilas_word;
          tx_charisk <= ilas_k;
        end
        ST_DATA: begin
          tx_dataout <= (SCRAMBLE != 0) ? scr_word : tx_datain;
          tx_charisk <= '0;
        end
        default: begin
          tx_dataout <= {NB{8'hBC}};
          tx_charisk <= '1;
        end
      endcase
    end
  end
endmodule
